// File: rtl/lsq_issue_arbiter_if.sv
// Memory-port bundle between the load/store issue arbiter (master) and the
// single data-memory port (slave): request/ack handshake plus address/data.
interface lsq_issue_arbiter_if #(
    parameter int OPRAND_WIDTH = 32
);
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [OPRAND_WIDTH-1:0] mem_addr_o;
    logic [OPRAND_WIDTH-1:0] mem_wdata_o;
    logic                    mem_ack_i;
    logic [OPRAND_WIDTH-1:0] mem_rdata_i;

    // Handshake: mem_req_o and all mem_* request fields stay stable until the
    // cycle mem_ack_i is sampled high; that edge completes the request and
    // mem_rdata_i is valid with it. mem_ack_i without mem_req_o is ignored.
    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/lsq_issue_arbiter.sv
// In-order load/store queue fed by two ALU lanes, drained one request at a
// time over the memory req/ack port, with a one-cycle load write-back strobe.
module lsq_issue_arbiter #(
    parameter int OPRAND_WIDTH = 32,
    parameter int OP_WIDTH     = 7,
    parameter int DEPTH        = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid1_i,
    input  logic                         valid2_i,
    input  logic [OP_WIDTH-1:0]          op_func1_i,
    input  logic [OP_WIDTH-1:0]          op_func2_i,
    input  logic [OPRAND_WIDTH-1:0]      result1_i,
    input  logic [OPRAND_WIDTH-1:0]      result2_i,
    input  logic [OPRAND_WIDTH-1:0]      data1_i,
    input  logic [OPRAND_WIDTH-1:0]      data2_i,
    input  logic [4:0]                   rd1_i,
    input  logic [4:0]                   rd2_i,
    input  logic                         flush_i,
    output logic                         ready_o,
    lsq_issue_arbiter_if.master          mem,
    output logic                         wb_valid_o,
    output logic [4:0]                   wb_rd_o,
    output logic [OPRAND_WIDTH-1:0]      wb_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         state_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [OP_WIDTH-1:0] LOAD  = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] STORE = OP_WIDTH'(7'b0100011);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t                  state_q, state_n;
    logic [PW-1:0]           head_q, tail_q, head_nx, tail2;
    logic [CW-1:0]           count_q, n_push;
    logic                    we_q    [DEPTH];
    logic [OPRAND_WIDTH-1:0] addr_q  [DEPTH];
    logic [OPRAND_WIDTH-1:0] wdata_q [DEPTH];
    logic [4:0]              rd_q    [DEPTH];

    logic                    is_mem1, is_mem2, push1, push2, pop, issue;
    logic                    sel_we;
    logic [OPRAND_WIDTH-1:0] sel_addr, sel_wdata;

    assign is_mem1 = (op_func1_i == LOAD) || (op_func1_i == STORE);
    assign is_mem2 = (op_func2_i == LOAD) || (op_func2_i == STORE);
    assign ready_o = (count_q <= CW'(DEPTH - 2));
    assign push1   = valid1_i && ready_o && is_mem1 && !flush_i;
    assign push2   = valid2_i && ready_o && is_mem2 && !flush_i;
    assign n_push  = CW'(push1) + CW'(push2);
    assign pop     = (state_q == REQ) && mem.mem_ack_i;
    assign head_nx = head_q + 1'b1;
    assign tail2   = push1 ? tail_q + 1'b1 : tail_q;
    assign count_o = count_q;
    assign state_o = (state_q == REQ);

    // Next request source: the head when starting from IDLE; after an ack the
    // entry behind the head, or a same-cycle push when the queue ran empty.
    always_comb begin
        state_n   = state_q;
        issue     = 1'b0;
        sel_we    = we_q[head_q];
        sel_addr  = addr_q[head_q];
        sel_wdata = wdata_q[head_q];
        case (state_q)
            IDLE: begin
                if (count_q != '0 && !flush_i) begin
                    state_n = REQ;
                    issue   = 1'b1;
                end
            end
            REQ: begin
                if (pop) begin
                    if (flush_i) begin
                        state_n = IDLE;
                    end else if (count_q > CW'(1)) begin
                        issue     = 1'b1;
                        sel_we    = we_q[head_nx];
                        sel_addr  = addr_q[head_nx];
                        sel_wdata = wdata_q[head_nx];
                    end else if (push1) begin
                        issue     = 1'b1;
                        sel_we    = (op_func1_i == STORE);
                        sel_addr  = result1_i;
                        sel_wdata = data1_i;
                    end else if (push2) begin
                        issue     = 1'b1;
                        sel_we    = (op_func2_i == STORE);
                        sel_addr  = result2_i;
                        sel_wdata = data2_i;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push1) begin
            we_q[tail_q]    <= (op_func1_i == STORE);
            addr_q[tail_q]  <= result1_i;
            wdata_q[tail_q] <= data1_i;
            rd_q[tail_q]    <= rd1_i;
        end
        if (push2) begin
            we_q[tail2]    <= (op_func2_i == STORE);
            addr_q[tail2]  <= result2_i;
            wdata_q[tail2] <= data2_i;
            rd_q[tail2]    <= rd2_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_wdata_o <= '0;
            wb_valid_o      <= 1'b0;
            wb_rd_o         <= '0;
            wb_data_o       <= '0;
        end else begin
            state_q       <= state_n;
            mem.mem_req_o <= (state_n == REQ);
            if (issue) begin
                mem.mem_we_o    <= sel_we;
                mem.mem_addr_o  <= sel_addr;
                mem.mem_wdata_o <= sel_wdata;
            end
            wb_valid_o <= pop && !mem.mem_we_o;
            if (pop && !mem.mem_we_o) begin
                wb_rd_o   <= rd_q[head_q];
                wb_data_o <= mem.mem_rdata_i;
            end
            if (pop) head_q <= head_nx;
            // Flush keeps only an un-acked in-flight head; everything else goes.
            if (flush_i) begin
                if (state_q == REQ && !pop) begin
                    tail_q  <= head_nx;
                    count_q <= CW'(1);
                end else begin
                    tail_q  <= pop ? head_nx : head_q;
                    count_q <= '0;
                end
            end else begin
                tail_q  <= tail_q + PW'(n_push);
                count_q <= count_q + n_push - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_lsq_issue_arbiter.sv
// Bench for lsq_issue_arbiter: directed scenarios then random traffic, all
// checked each cycle against a queue-based transaction model.
module tb_lsq_issue_arbiter;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = 1 + W + W + 5;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] RTYPE = 7'b0110011;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid1, valid2, flush;
    logic [6:0]    op1, op2;
    logic [W-1:0]  res1, res2, data1, data2;
    logic [4:0]    rd1, rd2;
    logic          ready, wb_valid, state_dbg;
    logic [4:0]    wb_rd;
    logic [W-1:0]  wb_data;
    logic [CW-1:0] count;

    lsq_issue_arbiter_if #(.OPRAND_WIDTH(W)) mem_bus ();

    lsq_issue_arbiter #(.OPRAND_WIDTH(W), .OP_WIDTH(7), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .valid1_i(valid1), .valid2_i(valid2),
        .op_func1_i(op1), .op_func2_i(op2),
        .result1_i(res1), .result2_i(res2),
        .data1_i(data1), .data2_i(data2),
        .rd1_i(rd1), .rd2_i(rd2),
        .flush_i(flush), .ready_o(ready),
        .mem(mem_bus),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .count_o(count), .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    // Model: exp_q holds {we, addr, wdata, rd} of every accepted, not yet
    // acked entry; busy says its front is currently being requested.
    logic [EW-1:0] exp_q[$];
    bit            busy;
    bit            exp_wb;
    logic [4:0]    exp_wb_rd;
    logic [W-1:0]  exp_wb_data;
    int            checks = 0;
    int            errors = 0;

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mem(logic [6:0] op);
        return (op == LOAD) || (op == STORE);
    endfunction

    task automatic model_edge();
        int            size0 = exp_q.size();
        bit            rdy   = (DEPTH - size0) >= 2;
        bit            popped = busy && mem_bus.mem_ack_i;
        logic [EW-1:0] e;
        logic [EW-1:0] p[$];
        if (!flush && rdy && valid1 && is_mem(op1)) p.push_back({op1 == STORE, res1, data1, rd1});
        if (!flush && rdy && valid2 && is_mem(op2)) p.push_back({op2 == STORE, res2, data2, rd2});
        exp_wb = 0;
        if (popped) begin
            e = exp_q.pop_front();
            if (!e[EW-1]) begin
                exp_wb      = 1;
                exp_wb_rd   = e[4:0];
                exp_wb_data = mem_bus.mem_rdata_i;
            end
        end
        if (flush) begin
            if (busy && !popped) begin
                e = exp_q[0];
                exp_q.delete();
                exp_q.push_back(e);
            end else begin
                exp_q.delete();
                busy = 0;
            end
        end else begin
            foreach (p[i]) exp_q.push_back(p[i]);
            if (popped)     busy = exp_q.size() > 0;
            else if (!busy) busy = size0 > 0;
        end
    endtask

    task automatic compare();
        logic [EW-1:0] h;
        check("mem_req", mem_bus.mem_req_o, busy);
        check("count", count, exp_q.size());
        check("ready", ready, (DEPTH - exp_q.size()) >= 2);
        check("wb_valid", wb_valid, exp_wb);
        if (busy) begin
            h = exp_q[0];
            check("mem_we", mem_bus.mem_we_o, h[EW-1]);
            check("mem_addr", mem_bus.mem_addr_o, h[EW-2 -: W]);
            check("mem_wdata", mem_bus.mem_wdata_o, h[4+W -: W]);
        end
        if (exp_wb) begin
            check("wb_rd", wb_rd, exp_wb_rd);
            check("wb_data", wb_data, exp_wb_data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic quiet();
        valid1 = 0; valid2 = 0; flush = 0; mem_bus.mem_ack_i = 0;
    endtask

    task automatic lane1(logic [6:0] op, logic [W-1:0] a, logic [W-1:0] d, logic [4:0] r);
        valid1 = 1; op1 = op; res1 = a; data1 = d; rd1 = r;
    endtask

    task automatic lane2(logic [6:0] op, logic [W-1:0] a, logic [W-1:0] d, logic [4:0] r);
        valid2 = 1; op2 = op; res2 = a; data2 = d; rd2 = r;
    endtask

    initial begin
        rst = 1; quiet();
        op1 = RTYPE; op2 = RTYPE; res1 = 0; res2 = 0; data1 = 0; data2 = 0;
        rd1 = 0; rd2 = 0; mem_bus.mem_rdata_i = 0;
        busy = 0; exp_wb = 0;
        #1;
        check("rst_req", mem_bus.mem_req_o, 0);
        check("rst_we", mem_bus.mem_we_o, 0);
        check("rst_addr", mem_bus.mem_addr_o, 0);
        check("rst_wdata", mem_bus.mem_wdata_o, 0);
        check("rst_count", count, 0);
        check("rst_ready", ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // Single load, acked two cycles after the request appears.
        lane1(LOAD, 32'h100, 32'h0, 5'd5);
        step(); quiet();
        step(); step();
        mem_bus.mem_ack_i = 1; mem_bus.mem_rdata_i = 32'hDEADBEEF;
        step();
        check("single_wb_data", wb_data, 32'hDEADBEEF);
        check("single_wb_rd", wb_rd, 5);
        quiet();
        step();

        // Dual issue: lane-1 store ahead of lane-2 load, ack tied high.
        lane1(STORE, 32'h10, 32'hAA, 5'd0);
        lane2(LOAD, 32'h20, 32'h0, 5'd7);
        mem_bus.mem_ack_i = 1; mem_bus.mem_rdata_i = 32'h1234;
        step();
        valid1 = 0; valid2 = 0;
        repeat (4) step();
        quiet();

        // Non-memory opcodes are ignored.
        lane1(RTYPE, 32'h30, 32'h1, 5'd1);
        lane2(RTYPE, 32'h34, 32'h2, 5'd2);
        repeat (2) step();
        quiet();

        // Backpressure: three loads fill to count 3, a fourth push is dropped.
        for (int i = 0; i < 4; i++) begin
            lane1(LOAD, 32'h200 + 32'(i * 4), 32'h0, 5'(8 + i));
            step();
        end
        check("full_count", count, 3);
        check("full_ready", ready, 0);
        quiet();
        mem_bus.mem_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
            mem_bus.mem_rdata_i = 32'hC0DE0000 + 32'(i);
            step();
        end
        quiet();
        step();

        // Flush while the head at 0x40 is in flight.
        lane1(LOAD, 32'h40, 32'h0, 5'd3);
        lane2(LOAD, 32'h44, 32'h0, 5'd4);
        step(); valid2 = 0;
        lane1(LOAD, 32'h48, 32'h0, 5'd6);
        step(); quiet();
        step();
        flush = 1;
        step();
        check("flush_count", count, 1);
        check("flush_addr", mem_bus.mem_addr_o, 32'h40);
        flush = 0;
        repeat (2) step();
        mem_bus.mem_ack_i = 1; mem_bus.mem_rdata_i = 32'h4040;
        step();
        quiet();
        repeat (3) step();

        // Asynchronous reset in the middle of a request.
        lane1(LOAD, 32'h80, 32'h0, 5'd9);
        step(); quiet();
        step();
        #3 rst = 1;
        #1;
        check("arst_req", mem_bus.mem_req_o, 0);
        check("arst_count", count, 0);
        check("arst_ready", ready, 1);
        exp_q.delete(); busy = 0; exp_wb = 0;
        @(negedge clk);
        rst = 0;
        mem_bus.mem_ack_i = 1;
        step();
        check("arst_no_wb", wb_valid, 0);
        quiet();

        // Random traffic.
        for (int n = 0; n < 1000; n++) begin
            valid1 = 1'($urandom_range(0, 1));
            valid2 = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: op1 = LOAD; 1: op1 = STORE; default: op1 = RTYPE;
            endcase
            case ($urandom_range(0, 2))
                0: op2 = LOAD; 1: op2 = STORE; default: op2 = RTYPE;
            endcase
            res1 = $urandom; res2 = $urandom; data1 = $urandom; data2 = $urandom;
            rd1 = 5'($urandom_range(0, 31)); rd2 = 5'($urandom_range(0, 31));
            flush = ($urandom_range(0, 19) == 0);
            mem_bus.mem_ack_i = 1'($urandom_range(0, 1));
            mem_bus.mem_rdata_i = $urandom;
            step();
        end
        quiet();
        mem_bus.mem_ack_i = 1;
        repeat (8) step();
        check("drain_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsq_issue_arbiter.md
# lsq_issue_arbiter

Sequential load/store issue controller between the two ALU lanes and the single data-memory port. Each cycle it captures the LOAD/STORE operations (address = ALU result) from lane 1 and lane 2 into an in-order queue. It then drains the queue one request at a time over a req/ack memory handshake and returns load data to the write-back stage. It supersedes purely combinational lane selection: simultaneous memory ops on both lanes are both kept, with lane 1 first.

## Interface
- OPRAND_WIDTH, 32, address/data width
- OP_WIDTH, 7, opcode width; LOAD = 7'b0000011, STORE = 7'b0100011
- DEPTH, 4, queue entries; power of two, ≥ 2
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid1_i, valid2_i  in  1  lane issues an instruction this cycle
- op_func1_i, op_func2_i  in  OP_WIDTH  lane opcode
- result1_i, result2_i  in  OPRAND_WIDTH  lane ALU result (memory address)
- data1_i, data2_i  in  OPRAND_WIDTH  store data
- rd1_i, rd2_i  in  5  load destination register
- flush_i  in  1  discard all queued, not-yet-requested entries
- ready_o  out  1  at least 2 free entries
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  1 = store, 0 = load
- mem_addr_o, mem_wdata_o  out  OPRAND_WIDTH  request address / store data
- mem_ack_i  in  1  memory accepts/completes current request
- mem_rdata_i  in  OPRAND_WIDTH  load data, valid with mem_ack_i
- wb_valid_o  out  1  one-cycle load write-back strobe
- wb_rd_o  out  5  load destination
- wb_data_o  out  OPRAND_WIDTH  load data
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Lane n qualifies when valid_n && ready_o && op_func_n ∈ {LOAD, STORE}. Other opcodes and unqualified lanes are ignored. The upstream stalls on !ready_o; a push while !ready_o is dropped.
- Entry = {we, addr, wdata, rd}. Both lanes qualifying in one cycle: lane 1 goes to tail, lane 2 to tail+1. Pointers wrap modulo DEPTH.
- ready_o = (DEPTH − count_o) ≥ 2, combinational from registered count.
- FSM IDLE/REQ:
  - IDLE: if count_o > 0 and !flush_i, load the head into the registered mem_* outputs, assert mem_req_o, and go to REQ.
  - REQ: hold mem_req_o and all mem_* outputs stable until mem_ack_i. On ack, pop the head. If the queue still has an entry (counting a same-cycle push to an empty remainder), present it next cycle and stay in REQ; otherwise drop mem_req_o and go to IDLE.
- A load ack captures mem_rdata_i and the entry's rd into wb_data_o/wb_rd_o and pulses wb_valid_o. A store ack produces no write-back.
- flush_i:
  - Clears every entry except an in-flight head in REQ. That request stays asserted until ack and completes normally, including load write-back.
  - Same-cycle pushes are discarded.
  - After flush, count_o = 1 if in REQ, else 0.
- Same-cycle pop and push(es): count_o = count + pushes − 1. The queue never exceeds DEPTH because of the ready_o rule.

## Timing
- Reset values: all pointers and count_o = 0; state = IDLE; mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, wb_valid_o, wb_rd_o, wb_data_o = 0; ready_o = 1.
- Reset asserted mid-REQ: request is abandoned and mem_req_o drops asynchronously; all queued entries are lost.
- Push at edge N → count_o updates after N; mem_req_o high from edge N+1 if idle (1-cycle issue latency).
- mem_ack_i sampled at edge K → wb_valid_o high for exactly cycle K..K+1. The next request, if any, is presented from edge K (back-to-back, no bubble).
- mem_ack_i while mem_req_o = 0 is ignored.
- Throughput: 1 request per cycle with ack held high; intake up to 2 per cycle.

## Test plan
- Single load: lane 1 LOAD addr 0x100, rd 5; ack 2 cycles after req with rdata 0xDEADBEEF → mem_addr_o = 0x100, mem_we_o = 0 held until ack; wb_valid_o one cycle, wb_rd_o = 5, wb_data_o = 0xDEADBEEF.
- Dual issue ordering: lane 1 STORE 0x10/0xAA and lane 2 LOAD 0x20 in the same cycle, ack tied high → store to 0x10 on consecutive cycle before load 0x20; count_o 2→1→0.
- Non-memory ops: op 7'b0110011 on both lanes with valid → count_o stays 0, mem_req_o stays 0.
- Full/backpressure (DEPTH = 4), ack held low:
  - 3 loads pushed → ready_o = 0 at count 3;
  - a lane push while !ready_o is dropped;
  - acking all three drains exactly 3 requests in order.
- Flush in flight: 3 entries queued, REQ active on head 0x40, flush_i pulse → count_o = 1; req 0x40 held until ack, then IDLE, no further requests.
- Async reset mid-REQ: rst_i rises between edges while mem_req_o = 1 → mem_req_o = 0 and count_o = 0 immediately, ready_o = 1; no wb_valid_o after release.
